// File: rtl/align_shifter_seq.sv
// Multi-cycle right-shift aligner for floating-point mantissas. Shifts at most STEP bits per
// cycle and produces guard, round and sticky bits for the following rounding stage.
module align_shifter_seq #(
  parameter int unsigned MANT_W = 24,
  parameter int unsigned STEP   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [MANT_W-1:0] mant_in,
  input  logic [7:0]        shamt,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [MANT_W-1:0] mant_out,
  output logic              guard,
  output logic              round_b,
  output logic              sticky
);

  localparam int unsigned VecW = MANT_W + 2;
  localparam logic [7:0] VecWL = 8'(VecW);
  localparam logic [7:0] StepL = 8'(STEP);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e          state_q;
  logic [VecW-1:0] vec_q;      // {mant, guard, round}
  logic            sticky_q;
  logic [7:0]      rem_q;
  logic            in_ready_q;
  logic            out_valid_q;

  logic [7:0]      step_amt;
  logic [7:0]      eff_amt;
  logic [VecW-1:0] vec_shifted;
  logic [VecW-1:0] lost_mask;
  logic            lost_any;

  always_comb begin
    step_amt    = (rem_q > StepL) ? StepL : rem_q;
    eff_amt     = (shamt > VecWL) ? VecWL : shamt;
    vec_shifted = vec_q >> step_amt;
    // Bits falling off the bottom of {mant, guard, round} feed the sticky bit.
    lost_mask   = ~({VecW{1'b1}} << step_amt);
    lost_any    = |(vec_q & lost_mask);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      vec_q       <= '0;
      sticky_q    <= 1'b0;
      rem_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            state_q    <= StShift;
            vec_q      <= {mant_in, 2'b00};
            sticky_q   <= 1'b0;
            rem_q      <= eff_amt;
            in_ready_q <= 1'b0;
          end
        end
        StShift: begin
          vec_q    <= vec_shifted;
          sticky_q <= sticky_q | lost_any;
          rem_q    <= rem_q - step_amt;
          if (rem_q == step_amt) begin
            state_q     <= StDone;
            out_valid_q <= 1'b1;
          end
        end
        StDone: begin
          if (out_ready) begin
            state_q     <= StIdle;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q     <= StIdle;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign mant_out  = vec_q[VecW-1:2];
  assign guard     = vec_q[1];
  assign round_b   = vec_q[0];
  assign sticky    = sticky_q;

endmodule
